// File: rtl/gouram_trace_ctrl_if.sv
// Trace output bus between gouram_trace_ctrl (master) and the trace sink (slave).
interface gouram_trace_ctrl_if #(
    parameter int DATA_W = 80
) ();
    logic              trace_valid_o;
    logic              trace_ready_i;
    logic [DATA_W-1:0] trace_data_o;

    modport master (output trace_valid_o, output trace_data_o, input trace_ready_i);
    modport slave  (input trace_valid_o, input trace_data_o, output trace_ready_i);
endinterface

// File: rtl/gouram_trace_ctrl.sv
// Gouram trace capture/output controller: timestamps records, buffers them in a FWFT FIFO,
// locks capture on repeated-address loops. Optional macro GOURAM_TS_DELTA_EN selects delta timestamps.
module gouram_trace_ctrl #(
    parameter int ADDR_WIDTH       = 16,
    parameter int REC_WIDTH        = 32,
    parameter int TS_WIDTH         = 32,
    parameter int FIFO_DEPTH       = 8,
    parameter int REPEAT_WINDOW    = 4,
    parameter int REPEAT_THRESHOLD = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                rec_valid_i,
    input  logic [ADDR_WIDTH-1:0]               rec_addr_i,
    input  logic [REC_WIDTH-1:0]                rec_data_i,
    input  logic                                rearm_i,
    gouram_trace_ctrl_if.master                 trace_if,
    output logic                                trace_capture_enable,
    output logic                                lock,
    output logic [15:0]                         drop_count_o,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_level_o
);
    localparam int DW  = TS_WIDTH + ADDR_WIDTH + REC_WIDTH;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int LW  = PW + 1;
    localparam int HCW = $clog2(REPEAT_THRESHOLD + 1);

    typedef enum logic [1:0] {S_CAPTURE, S_DRAIN, S_LOCKED} state_e;

    state_e                  state_q;
    logic                    cap_en_q, lock_q;
    logic [TS_WIDTH-1:0]     ts_q;
    logic [DW-1:0]           mem [FIFO_DEPTH];
    logic [PW-1:0]           rd_ptr_q, wr_ptr_q;
    logic [LW-1:0]           cnt_q;
    logic [ADDR_WIDTH-1:0]   hist_addr_q [REPEAT_WINDOW];
    logic [REPEAT_WINDOW-1:0] hist_vld_q;
    logic [HCW-1:0]          hits_q, hits_d;
    logic [15:0]             drop_q;
    logic [TS_WIDTH-1:0]     ts_field;

    logic hit, accept, trigger, pop, full, push, drop, rearm_go, valid;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < REPEAT_WINDOW; i++) begin
            if (hist_vld_q[i] && (hist_addr_q[i] == rec_addr_i)) hit = 1'b1;
        end
        accept   = (state_q == S_CAPTURE) && rec_valid_i;
        hits_d   = hit ? (hits_q + HCW'(1)) : '0;
        trigger  = accept && (hits_d == HCW'(REPEAT_THRESHOLD));
        valid    = (cnt_q != '0);
        pop      = valid && trace_if.trace_ready_i;
        full     = (cnt_q == LW'(FIFO_DEPTH));
        push     = accept && !trigger && (!full || pop);
        drop     = accept && !trigger && full && !pop;
        rearm_go = (state_q == S_LOCKED) && rearm_i;
    end

`ifdef GOURAM_TS_DELTA_EN
    logic [TS_WIDTH-1:0] dlt_q;
    logic                first_q;

    // first_q marks that no record has been written since reset or re-arm
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dlt_q   <= '0;
            first_q <= 1'b1;
        end else if (push) begin
            dlt_q   <= TS_WIDTH'(1);
            first_q <= 1'b0;
        end else begin
            if (rearm_go) first_q <= 1'b1;
            if (dlt_q != '1) dlt_q <= dlt_q + TS_WIDTH'(1);
        end
    end

    assign ts_field = first_q ? ts_q : dlt_q;
`else
    assign ts_field = ts_q;
`endif

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {ts_field, rec_addr_i, rec_data_i};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q     <= '1;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            ts_q <= ts_q + TS_WIDTH'(1);
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      cnt_q <= cnt_q + LW'(1);
            else if (pop && !push) cnt_q <= cnt_q - LW'(1);
        end
    end

    // Control FSM; history, hit count and drop counter move with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_CAPTURE;
            cap_en_q   <= 1'b1;
            lock_q     <= 1'b0;
            hits_q     <= '0;
            hist_vld_q <= '0;
            drop_q     <= '0;
            for (int i = 0; i < REPEAT_WINDOW; i++) hist_addr_q[i] <= '0;
        end else begin
            cap_en_q <= (state_q == S_CAPTURE);
            lock_q   <= (state_q != S_CAPTURE);
            case (state_q)
                S_CAPTURE: begin
                    if (accept) hits_q <= hits_d;
                    if (trigger) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (cnt_q == '0) state_q <= S_LOCKED;
                end
                S_LOCKED: begin
                    if (rearm_i) begin
                        state_q    <= S_CAPTURE;
                        hits_q     <= '0;
                        hist_vld_q <= '0;
                    end
                end
                default: state_q <= S_CAPTURE;
            endcase
            if (push) begin
                for (int i = REPEAT_WINDOW - 1; i > 0; i--) begin
                    hist_addr_q[i] <= hist_addr_q[i-1];
                    hist_vld_q[i]  <= hist_vld_q[i-1];
                end
                hist_addr_q[0] <= rec_addr_i;
                hist_vld_q[0]  <= 1'b1;
            end
            if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
        end
    end

    assign trace_if.trace_valid_o = valid;
    assign trace_if.trace_data_o  = valid ? mem[rd_ptr_q] : '0;
    assign trace_capture_enable   = cap_en_q;
    assign lock                   = lock_q;
    assign drop_count_o           = drop_q;
    assign fifo_level_o           = cnt_q;
endmodule

// File: tb/tb_gouram_trace_ctrl.sv
// Bench for gouram_trace_ctrl: directed scenarios with literal expectations plus randomized
// traffic checked every cycle against a queue-based behavioural model.
module tb_gouram_trace_ctrl;
    localparam int DEPTH = 8;
    localparam int WIN   = 4;
    localparam int THR   = 2;
    localparam int DW    = 80;
    localparam int CAPT  = 0;
    localparam int DRN   = 1;
    localparam int LCK   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rec_valid = 1'b0;
    logic [15:0] rec_addr = '0;
    logic [31:0] rec_data = '0;
    logic        rearm = 1'b0;
    logic        cap_en, lock_o;
    logic [15:0] drop;
    logic [3:0]  level;

    gouram_trace_ctrl_if #(.DATA_W(DW)) tif ();

    gouram_trace_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .rec_valid_i          (rec_valid),
        .rec_addr_i           (rec_addr),
        .rec_data_i           (rec_data),
        .rearm_i              (rearm),
        .trace_if             (tif),
        .trace_capture_enable (cap_en),
        .lock                 (lock_o),
        .drop_count_o         (drop),
        .fifo_level_o         (level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model
    bit [79:0]   mq[$];
    bit [15:0]   mh[$];
    int          m_hc, m_mode, m_drop;
    bit          m_cap_en, m_lock, m_first;
    longint      m_abs, m_last;

    task automatic m_reset();
        mq.delete();
        mh.delete();
        m_hc = 0; m_mode = CAPT; m_drop = 0;
        m_cap_en = 1'b1; m_lock = 1'b0; m_first = 1'b1;
        m_abs = -1; m_last = 0;
    endtask

    task automatic m_step();
        bit        pop, hit, do_push;
        int        sz;
        longint    d;
        bit [31:0] fld;
        sz = mq.size();
        pop = (sz > 0) && tif.trace_ready_i;
        do_push = 1'b0;
        m_cap_en = (m_mode == CAPT);
        m_lock   = (m_mode != CAPT);
        if (m_mode == CAPT && rec_valid) begin
            hit = 1'b0;
            foreach (mh[i]) if (mh[i] == rec_addr) hit = 1'b1;
            m_hc = hit ? m_hc + 1 : 0;
            if (m_hc == THR) m_mode = DRN;
            else if (sz < DEPTH || pop) do_push = 1'b1;
            else if (m_drop < 65535) m_drop++;
        end else if (m_mode == DRN) begin
            if (sz == 0) m_mode = LCK;
        end else if (m_mode == LCK && rearm) begin
            m_mode = CAPT; mh.delete(); m_hc = 0; m_first = 1'b1;
        end
        if (pop) void'(mq.pop_front());
        if (do_push) begin
`ifdef GOURAM_TS_DELTA_EN
            d = m_abs - m_last;
            if (m_first) fld = m_abs[31:0];
            else fld = (d > 64'sh0FFFF_FFFF) ? 32'hFFFF_FFFF : d[31:0];
`else
            d = 0;
            fld = m_abs[31:0];
`endif
            mq.push_back({fld, rec_addr, rec_data});
            mh.push_front(rec_addr);
            if (mh.size() > WIN) void'(mh.pop_back());
            m_last = m_abs; m_first = 1'b0;
        end
        m_abs++;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("valid", 80'(tif.trace_valid_o), 80'(mq.size() != 0));
            chk("level", 80'(level), 80'(mq.size()));
            if (mq.size() != 0) chk("data", tif.trace_data_o, mq[0]);
            chk("drop", 80'(drop), 80'(m_drop));
            chk("cap_en", 80'(cap_en), 80'(m_cap_en));
            chk("lock", 80'(lock_o), 80'(m_lock));
        end
    end

    logic [79:0] popped[$];
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tif.trace_valid_o && tif.trace_ready_i) popped.push_back(tif.trace_data_o);
        end
    end

    function automatic logic [79:0] pe(input int i);
        logic [79:0] e;
        e = (i < popped.size()) ? popped[i] : '1;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rec_valid = 1'b0; rearm = 1'b0; tif.trace_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        popped.delete();
    endtask

    task automatic rec(input logic [15:0] a, input logic [31:0] d);
        rec_valid = 1'b1; rec_addr = a; rec_data = d;
        tick();
        rec_valid = 1'b0;
    endtask

    logic [79:0] e;

    initial begin
        tif.trace_ready_i = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_valid", 80'(tif.trace_valid_o), 80'(0));
        chk("rst_data", tif.trace_data_o, 80'(0));
        chk("rst_level", 80'(level), 80'(0));
        chk("rst_cap_en", 80'(cap_en), 80'(1));
        chk("rst_lock", 80'(lock_o), 80'(0));
        chk("rst_drop", 80'(drop), 80'(0));

        // Three records on cycles 3,4,5
        do_reset();
        tif.trace_ready_i = 1'b1;
        repeat (3) tick();
        rec(16'h0010, 32'hA0);
        rec(16'h0014, 32'hA1);
        rec(16'h0018, 32'hA2);
        repeat (4) tick();
        chk("t1_count", 80'(popped.size()), 80'(3));
        e = pe(0); chk("t1_ts0", 80'(e[79:48]), 80'(3));
`ifdef GOURAM_TS_DELTA_EN
        e = pe(1); chk("t1_ts1", 80'(e[79:48]), 80'(1));
        e = pe(2); chk("t1_ts2", 80'(e[79:48]), 80'(1));
`else
        e = pe(1); chk("t1_ts1", 80'(e[79:48]), 80'(4));
        e = pe(2); chk("t1_ts2", 80'(e[79:48]), 80'(5));
`endif
        e = pe(2); chk("t1_addr2", 80'(e[47:32]), 80'(16'h0018));
        chk("t1_lock", 80'(lock_o), 80'(0));
        chk("t1_drop", 80'(drop), 80'(0));

        // Loop detection, then records ignored while locked, then re-arm
        do_reset();
        tif.trace_ready_i = 1'b1;
        rec(16'h0010, 32'h1); rec(16'h0014, 32'h2); rec(16'h0010, 32'h3); rec(16'h0014, 32'h4);
        repeat (5) tick();
        chk("t2_count", 80'(popped.size()), 80'(3));
        chk("t2_lock", 80'(lock_o), 80'(1));
        chk("t2_cap_en", 80'(cap_en), 80'(0));
        chk("t2_level", 80'(level), 80'(0));
        rec(16'h0040, 32'h5); rec(16'h0044, 32'h6);
        tick();
        chk("t2_locked_drop", 80'(drop), 80'(0));
        chk("t2_locked_level", 80'(level), 80'(0));
        rearm = 1'b1; tick(); rearm = 1'b0;
        rec(16'h0010, 32'h7); rec(16'h0014, 32'h8);
        repeat (4) tick();
        chk("t2_rearm_count", 80'(popped.size()), 80'(5));
        e = pe(3); chk("t2_rearm_addr", 80'(e[47:32]), 80'(16'h0010));
        chk("t2_rearm_cap_en", 80'(cap_en), 80'(1));
        chk("t2_rearm_lock", 80'(lock_o), 80'(0));

        // Fill, overflow, simultaneous push/pop at full, drain in order
        do_reset();
        for (int i = 0; i < 10; i++) rec(16'(16'h0100 + 4 * i), 32'(i));
        repeat (2) tick();
        chk("t3_level", 80'(level), 80'(8));
        chk("t3_drop", 80'(drop), 80'(2));
        e = tif.trace_data_o; chk("t3_head", 80'(e[47:32]), 80'(16'h0100));
        tif.trace_ready_i = 1'b1;
        rec(16'h0200, 32'hBEEF);
        tif.trace_ready_i = 1'b0;
        tick();
        chk("t3_pp_level", 80'(level), 80'(8));
        chk("t3_pp_drop", 80'(drop), 80'(2));
        tif.trace_ready_i = 1'b1;
        repeat (10) tick();
        chk("t3_count", 80'(popped.size()), 80'(9));
        e = pe(7); chk("t3_pop7", 80'(e[47:32]), 80'(16'h011C));
        e = pe(8); chk("t3_pop8", 80'(e[47:32]), 80'(16'h0200));

        // Re-arm during DRAIN has no effect
        do_reset();
        rec(16'h0020, 32'h1); rec(16'h0024, 32'h2); rec(16'h0020, 32'h3); rec(16'h0024, 32'h4);
        tick();
        chk("t4_level", 80'(level), 80'(3));
        chk("t4_lock", 80'(lock_o), 80'(1));
        rearm = 1'b1; tick(); rearm = 1'b0;
        tif.trace_ready_i = 1'b1;
        repeat (6) tick();
        chk("t4_still_lock", 80'(lock_o), 80'(1));
        chk("t4_cap_en", 80'(cap_en), 80'(0));
        chk("t4_level0", 80'(level), 80'(0));

        // Asynchronous reset mid-DRAIN
        do_reset();
        rec(16'h0030, 32'h1); rec(16'h0034, 32'h2); rec(16'h0030, 32'h3); rec(16'h0034, 32'h4);
        tick();
        #3 rst = 1'b1;
        #1;
        chk("t5_valid", 80'(tif.trace_valid_o), 80'(0));
        chk("t5_lock", 80'(lock_o), 80'(0));
        chk("t5_level", 80'(level), 80'(0));
        chk("t5_cap_en", 80'(cap_en), 80'(1));

`ifdef GOURAM_TS_DELTA_EN
        do_reset();
        tif.trace_ready_i = 1'b1;
        repeat (5) tick();
        rec(16'h0050, 32'h1);
        repeat (3) tick();
        rec(16'h0054, 32'h2);
        repeat (3) tick();
        e = pe(0); chk("t6_ts0", 80'(e[79:48]), 80'(5));
        e = pe(1); chk("t6_ts1", 80'(e[79:48]), 80'(4));
`endif

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            rec_valid = ($urandom_range(0, 1) == 1);
            rec_addr  = 16'(16'h0010 + 4 * $urandom_range(0, 7));
            rec_data  = $urandom;
            tif.trace_ready_i = ((c % 200) < 40) ? 1'b0 : ($urandom_range(0, 3) != 0);
            rearm = ($urandom_range(0, 7) == 0);
            tick();
            if (c == 1000) begin
                #2 rst = 1'b1;
                tick(); tick();
                @(negedge clk);
                rst = 1'b0;
                tick();
            end
        end
        rec_valid = 1'b0; rearm = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
